// File: rtl/multicycle_alu_pkg.sv
// Shared op codes and FSM encodings for the multi-cycle execute ALU.
// Op code values match what the ALU control decoder emits.
package multicycle_alu_pkg;

   localparam logic [3:0] ALU_ADD = 4'b0000;
   localparam logic [3:0] ALU_SUB = 4'b0001;
   localparam logic [3:0] ALU_AND = 4'b0010;
   localparam logic [3:0] ALU_XOR = 4'b0011;
   localparam logic [3:0] ALU_LUI = 4'b1000;
   localparam logic [3:0] ALU_OR  = 4'b1001;
   localparam logic [3:0] ALU_SRL = 4'b1010;
   localparam logic [3:0] ALU_SLL = 4'b1100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == ALU_SLL) || (op == ALU_SRL);
   endfunction

endpackage

// File: rtl/multicycle_alu_shift_unit.sv
// Iterative one-bit-per-cycle shifter: shift register plus down-counter.
// value_o is the next shifted value so the caller can capture the final step.
module alu_shift_unit
   import multicycle_alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   load_i,
   input  logic                   step_i,
   input  logic                   left_i,
   input  logic [DATA_WIDTH-1:0]  data_i,
   input  logic [SHAMT_WIDTH-1:0] shamt_i,
   output logic [DATA_WIDTH-1:0]  value_o,
   output logic                   last_o
);

   logic [DATA_WIDTH-1:0]  sr;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic                   left;

   assign value_o = left ? (sr << 1) : (sr >> 1);
   assign last_o  = (cnt == SHAMT_WIDTH'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sr   <= '0;
         cnt  <= '0;
         left <= 1'b0;
      end else if (load_i) begin
         sr   <= data_i;
         cnt  <= shamt_i;
         left <= left_i;
      end else if (step_i) begin
         sr  <= value_o;
         cnt <= cnt - SHAMT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith, iterative SLL/SRL.
// start/busy/done handshake lets the control FSM stall on shifts.
module multicycle_alu
   import multicycle_alu_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int SHAMT_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [3:0]            ALU_Operation_i,
   input  logic [DATA_WIDTH-1:0] A_i,
   input  logic [DATA_WIDTH-1:0] B_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [DATA_WIDTH-1:0] Result_o,
   output logic                  Zero_o
);

   state_t                 state;
   logic [SHAMT_WIDTH-1:0] shamt;
   logic                   shift_op;
   logic                   long_op;
   logic [DATA_WIDTH-1:0]  fast_res;
   logic [DATA_WIDTH-1:0]  sh_value;
   logic                   sh_last;
   logic                   sh_load;
   logic                   sh_step;

   assign shamt    = B_i[SHAMT_WIDTH-1:0];
   assign shift_op = is_shift(ALU_Operation_i);
   assign long_op  = shift_op && (shamt != '0);
   assign sh_load  = (state == IDLE) && start_i && long_op;
   assign sh_step  = (state == SHIFT);

   // Shifts only reach this path with shamt==0, so they pass A through.
   always_comb begin
      fast_res = '0;
      case (ALU_Operation_i)
         ALU_ADD: fast_res = A_i + B_i;
         ALU_SUB: fast_res = A_i - B_i;
         ALU_AND: fast_res = A_i & B_i;
         ALU_XOR: fast_res = A_i ^ B_i;
         ALU_OR:  fast_res = A_i | B_i;
         ALU_LUI: fast_res = B_i;
         ALU_SRL: fast_res = A_i;
         ALU_SLL: fast_res = A_i;
         default: fast_res = '0;
      endcase
   end

   alu_shift_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .SHAMT_WIDTH(SHAMT_WIDTH)
   ) u_shift (
      .clk    (clk),
      .reset  (reset),
      .load_i (sh_load),
      .step_i (sh_step),
      .left_i (ALU_Operation_i == ALU_SLL),
      .data_i (A_i),
      .shamt_i(shamt),
      .value_o(sh_value),
      .last_o (sh_last)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         Result_o <= '0;
         Zero_o   <= 1'b1;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i) begin
                  if (long_op) begin
                     state  <= SHIFT;
                     busy_o <= 1'b1;
                  end else begin
                     state    <= DONE;
                     done_o   <= 1'b1;
                     Result_o <= fast_res;
                     Zero_o   <= (fast_res == '0);
                  end
               end
            end
            SHIFT: begin
               if (sh_last) begin
                  state    <= DONE;
                  busy_o   <= 1'b0;
                  done_o   <= 1'b1;
                  Result_o <= sh_value;
                  Zero_o   <= (sh_value == '0);
               end
            end
            DONE: state <= IDLE;
            default: begin
               state  <= IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu.
// Expected results are queued at drive time and popped on done_o.
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [3:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy_o;
   logic        done_o;
   logic [31:0] Result_o;
   logic        Zero_o;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        zero;
      int          lat;
   } exp_t;

   exp_t sb[$];
   int   passed = 0;
   int   total  = 0;

   multicycle_alu #(
      .DATA_WIDTH (32),
      .SHAMT_WIDTH(5)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start_i        (start_i),
      .ALU_Operation_i(op),
      .A_i            (a),
      .B_i            (b),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .Result_o       (Result_o),
      .Zero_o         (Zero_o)
   );

   always #5 clk = ~clk;

   // Issue one op, return observed result, latency and busy cycles.
   task automatic run_op(input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, output logic [31:0] res,
                         output logic z, output int lat,
                         output int bcyc, output bit tmo);
      @(negedge clk);
      op = o; a = x; b = y; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h5555_5555; op = 4'b0011;
      lat = 1; bcyc = 0; tmo = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done_o) begin
            tmo = 1'b0;
            break;
         end
         if (busy_o) bcyc++;
         @(posedge clk);
         lat++;
      end
      res = Result_o;
      z   = Zero_o;
   endtask

   task automatic test_reset();
      reset = 1'b0; start_i = 1'b0; op = '0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({Result_o, Zero_o, busy_o, done_o} !== {32'd0, 3'b100})
         $display("FAIL reset res=%h z=%b busy=%b done=%b",
                  Result_o, Zero_o, busy_o, done_o);
      else passed++;
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({Result_o, Zero_o, busy_o, done_o} !== {32'd0, 3'b100})
         $display("FAIL reset_idle res=%h z=%b busy=%b done=%b",
                  Result_o, Zero_o, busy_o, done_o);
      else passed++;
   endtask

   task automatic test_single_cycle();
      logic [3:0]  ops[8] = '{4'b0000, 4'b0001, 4'b1001, 4'b1000,
                              4'b0000, 4'b0010, 4'b0011, 4'b0111};
      logic [31:0] as[8]  = '{32'd5, 32'd7, 32'h0000_00F0, 32'hFFFF_0000,
                              32'hFFFF_FFFF, 32'hF0F0_1234, 32'hFF00_FF00,
                              32'h1234_5678};
      logic [31:0] bs[8]  = '{32'd7, 32'd7, 32'h0000_000F, 32'h1234_5000,
                              32'd1, 32'h0FF0_00FF, 32'h0F0F_0F0F,
                              32'h9ABC_DEF0};
      logic [31:0] ex[8]  = '{32'd12, 32'd0, 32'h0000_00FF, 32'h1234_5000,
                              32'd0, 32'h00F0_0034, 32'hF00F_F00F, 32'd0};
      string       nm[8]  = '{"add", "sub", "or", "lui",
                              "add_wrap", "and", "xor", "undef"};
      logic [31:0] res;
      logic        z;
      int          lat, bc;
      bit          tmo;
      exp_t        e;
      for (int i = 0; i < 8; i++) begin
         sb.push_back('{nm[i], ex[i], ex[i] == 32'd0, 1});
         run_op(ops[i], as[i], bs[i], res, z, lat, bc, tmo);
         e = sb.pop_front();
         total++;
         if (tmo || res !== e.res || z !== e.zero || lat != e.lat || bc != 0)
            $display("FAIL %s res=%h z=%b lat=%0d busy=%0d tmo=%0b exp res=%h z=%b lat=%0d",
                     e.name, res, z, lat, bc, tmo, e.res, e.zero, e.lat);
         else passed++;
      end
   endtask

   task automatic test_shift();
      logic [3:0]  ops[4] = '{4'b1100, 4'b1010, 4'b1100, 4'b1010};
      logic [31:0] as[4]  = '{32'd1, 32'h8000_0000, 32'h0000_ABCD,
                              32'hF000_000F};
      logic [31:0] bs[4]  = '{32'h0000_0024, 32'd31, 32'hFFFF_FFE0,
                              32'd4};
      logic [31:0] ex[4]  = '{32'h10, 32'd1, 32'h0000_ABCD, 32'h0F00_0000};
      int          el[4]  = '{5, 32, 1, 5};
      string       nm[4]  = '{"sll4", "srl31", "sll0", "srl4"};
      logic [31:0] res;
      logic        z;
      int          lat, bc;
      bit          tmo;
      exp_t        e;
      for (int i = 0; i < 4; i++) begin
         sb.push_back('{nm[i], ex[i], ex[i] == 32'd0, el[i]});
         run_op(ops[i], as[i], bs[i], res, z, lat, bc, tmo);
         e = sb.pop_front();
         total++;
         if (tmo || res !== e.res || z !== e.zero ||
             lat != e.lat || bc != e.lat - 1)
            $display("FAIL %s res=%h z=%b lat=%0d busy=%0d tmo=%0b exp res=%h lat=%0d",
                     e.name, res, z, lat, bc, tmo, e.res, e.lat);
         else passed++;
      end
      repeat (3) @(negedge clk);
      total++;
      if (Result_o !== 32'h0F00_0000 || done_o !== 1'b0)
         $display("FAIL hold res=%h done=%b exp res=0f000000 done=0",
                  Result_o, done_o);
      else passed++;
   endtask

   task automatic test_start_ignored();
      int          dones = 0;
      logic [31:0] first = 32'hX;
      sb.push_back('{"ignored", 32'h300, 1'b0, 9});
      @(negedge clk);
      op = 4'b1100; a = 32'd3; b = 32'd8; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 2 || i == 4) begin
            start_i = 1'b1; op = 4'b0000; a = 32'd1; b = 32'd1;
         end else start_i = 1'b0;
         @(negedge clk);
         if (done_o) begin
            dones++;
            if (dones == 1) first = Result_o;
         end
      end
      start_i = 1'b0;
      begin
         exp_t e = sb.pop_front();
         total++;
         if (dones != 1 || first !== e.res)
            $display("FAIL %s dones=%0d res=%h exp dones=1 res=%h",
                     e.name, dones, first, e.res);
         else passed++;
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] res;
      logic        z;
      int          lat, bc;
      bit          tmo;
      int          dones = 0;
      exp_t        e;
      @(negedge clk);
      op = 4'b1100; a = 32'd1; b = 32'd20; start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
      repeat (10) @(negedge clk);
      total++;
      if (busy_o !== 1'b1)
         $display("FAIL abort_busy busy=%b exp 1", busy_o);
      else passed++;
      reset = 1'b0;
      #1;
      total++;
      if ({Result_o, Zero_o, busy_o, done_o} !== {32'd0, 3'b100})
         $display("FAIL abort_reset res=%h z=%b busy=%b done=%b",
                  Result_o, Zero_o, busy_o, done_o);
      else passed++;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done_o) dones++;
      end
      total++;
      if (dones != 0 || Result_o !== 32'd0)
         $display("FAIL abort_nodone dones=%0d res=%h exp 0 0",
                  dones, Result_o);
      else passed++;
      sb.push_back('{"post_abort_add", 32'd5, 1'b0, 1});
      run_op(4'b0000, 32'd2, 32'd3, res, z, lat, bc, tmo);
      e = sb.pop_front();
      total++;
      if (tmo || res !== e.res || z !== e.zero || lat != e.lat)
         $display("FAIL %s res=%h z=%b lat=%0d exp res=%h lat=%0d",
                  e.name, res, z, lat, e.res, e.lat);
      else passed++;
   endtask

   task automatic test_back_to_back();
      bit   seen = 1'b0;
      exp_t e;
      sb.push_back('{"b2b_first", 32'd3, 1'b0, 1});
      sb.push_back('{"b2b_second", 32'h0F, 1'b0, 2});
      @(negedge clk);
      op = 4'b0000; a = 32'd1; b = 32'd2; start_i = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done_o) begin
            seen = 1'b1;
            break;
         end
      end
      e = sb.pop_front();
      total++;
      if (!seen || Result_o !== e.res)
         $display("FAIL %s seen=%0b res=%h exp %h", e.name, seen,
                  Result_o, e.res);
      else passed++;
      op = 4'b0011; a = 32'hF0; b = 32'hFF;
      @(negedge clk);
      total++;
      if (done_o !== 1'b0 || Result_o !== 32'd3)
         $display("FAIL b2b_gap done=%b res=%h exp 0 3", done_o, Result_o);
      else passed++;
      @(negedge clk);
      start_i = 1'b0;
      e = sb.pop_front();
      total++;
      if (done_o !== 1'b1 || Result_o !== e.res || Zero_o !== e.zero)
         $display("FAIL %s done=%b res=%h exp 1 %h", e.name, done_o,
                  Result_o, e.res);
      else passed++;
      @(negedge clk);
      total++;
      if (done_o !== 1'b0)
         $display("FAIL b2b_pulse done=%b exp 0", done_o);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_single_cycle();
      test_shift();
      test_start_ignored();
      test_reset_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
